// File: rtl/lock_acq_ctrl.sv
// lock_acq_ctrl: saturated servo error stage plus lock-acquisition FSM that
// drives the on/hold controls of the downstream bit-shift servo filters.
module lock_acq_ctrl #(
  parameter int SIGNAL_SIZE = 25,
  parameter int CNT_W       = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lock_en,
  input  logic                          hold_req,
  input  logic signed [SIGNAL_SIZE-1:0] s_in,
  input  logic signed [SIGNAL_SIZE-1:0] setpoint,
  input  logic        [SIGNAL_SIZE-2:0] thr,
  input  logic        [CNT_W-1:0]       acq_cnt,
  input  logic        [CNT_W-1:0]       lost_cnt,
  output logic signed [SIGNAL_SIZE-1:0] err_out,
  output logic                          on_out,
  output logic                          hold_out,
  output logic                          locked,
  output logic        [1:0]             state,
  output logic        [15:0]            relock_num
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_HOLD    = 2'b11
  } state_t;

  // Symmetric limits so the magnitude of err_out always fits SIGNAL_SIZE-1 bits
  localparam logic signed [SIGNAL_SIZE:0] POS_LIM = {2'b00, {(SIGNAL_SIZE-1){1'b1}}};
  localparam logic signed [SIGNAL_SIZE:0] NEG_LIM = -POS_LIM;

  logic signed [SIGNAL_SIZE:0]   diff;
  logic signed [SIGNAL_SIZE-1:0] err_nxt;
  logic        [SIGNAL_SIZE-1:0] err_neg;
  logic        [SIGNAL_SIZE-2:0] err_abs;
  logic                          in_win;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_sat;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] acq_eff, lost_eff;
  logic [15:0]      relock_q, relock_nxt, relock_inc;
  logic             on_nxt, hold_nxt, locked_nxt;

  // Widened difference, clamped to the symmetric range
  always_comb begin
    diff = $signed({s_in[SIGNAL_SIZE-1], s_in}) - $signed({setpoint[SIGNAL_SIZE-1], setpoint});
    if (diff > POS_LIM)      err_nxt = POS_LIM[SIGNAL_SIZE-1:0];
    else if (diff < NEG_LIM) err_nxt = NEG_LIM[SIGNAL_SIZE-1:0];
    else                     err_nxt = diff[SIGNAL_SIZE-1:0];
  end

  // Error register, updated every cycle regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_out <= '0;
    else        err_out <= err_nxt;
  end

  // Window test on the registered error
  always_comb begin
    err_neg = '0 - err_out;
    err_abs = err_out[SIGNAL_SIZE-1] ? err_neg[SIGNAL_SIZE-2:0] : err_out[SIGNAL_SIZE-2:0];
    in_win  = (err_abs <= thr);
  end

  // Dwell-count helpers: saturating increment and zero-as-one thresholds
  always_comb begin
    cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    cnt_sat    = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
    acq_eff    = (acq_cnt  == '0) ? CNT_W'(1) : acq_cnt;
    lost_eff   = (lost_cnt == '0) ? CNT_W'(1) : lost_cnt;
    relock_inc = (relock_q == '1) ? relock_q : relock_q + 16'd1;
  end

  // State, counter and relock registers; Moore outputs registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      relock_q <= '0;
      on_out   <= 1'b0;
      hold_out <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      relock_q <= relock_nxt;
      on_out   <= on_nxt;
      hold_out <= hold_nxt;
      locked   <= locked_nxt;
    end
  end

  // Next-state logic with dwell counting
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = '0;
    relock_nxt = relock_q;
    if (!lock_en) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (in_win) begin
            if (cnt_inc >= {1'b0, acq_eff}) state_nxt = ST_LOCKED;
            else                            cnt_nxt   = cnt_sat;
          end
        end
        ST_LOCKED: begin
          if (hold_req) begin
            state_nxt = ST_HOLD;
          end else if (!in_win) begin
            if (cnt_inc >= {1'b0, lost_eff}) begin
              state_nxt  = ST_ACQUIRE;
              relock_nxt = relock_inc;
            end else begin
              cnt_nxt = cnt_sat;
            end
          end
        end
        ST_HOLD: begin
          if (!hold_req) state_nxt = ST_LOCKED;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode of the next state
  always_comb begin
    on_nxt     = (state_nxt == ST_LOCKED) || (state_nxt == ST_HOLD);
    hold_nxt   = (state_nxt == ST_HOLD);
    locked_nxt = on_nxt;
  end

  assign state      = state_q;
  assign relock_num = relock_q;

endmodule

// File: tb/tb_lock_acq_ctrl.sv
// Scoreboard bench for lock_acq_ctrl: stimulus queues expected outputs tagged
// with the cycle they must appear on; a negedge monitor pops and compares.
module tb_lock_acq_ctrl;

  localparam int S = 25;
  localparam int POS = 16777215;

  localparam logic [1:0] IDLE = 2'b00, ACQ = 2'b01, LCK = 2'b10, HLD = 2'b11;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               lock_en, hold_req;
  logic signed [S-1:0] s_in, setpoint;
  logic [S-2:0]       thr;
  logic [23:0]        acq_cnt, lost_cnt;
  logic signed [S-1:0] err_out;
  logic               on_out, hold_out, locked;
  logic [1:0]         state;
  logic [15:0]        relock_num;

  lock_acq_ctrl #(.SIGNAL_SIZE(S), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .lock_en(lock_en), .hold_req(hold_req),
    .s_in(s_in), .setpoint(setpoint), .thr(thr), .acq_cnt(acq_cnt),
    .lost_cnt(lost_cnt), .err_out(err_out), .on_out(on_out),
    .hold_out(hold_out), .locked(locked), .state(state), .relock_num(relock_num)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    bit              is_err;
    logic signed [S-1:0] err;
    logic [1:0]      st;
    logic            on, hold, lk;
    logic [15:0]     rn;
    string           name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int passed = 0;

  task automatic exp_err(input int dly, input string nm, input int v);
    exp_t e;
    e.cyc = cyc + dly; e.is_err = 1'b1; e.err = S'(v);
    e.st = '0; e.on = 1'b0; e.hold = 1'b0; e.lk = 1'b0; e.rn = '0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_fsm(input int dly, input string nm, input logic [1:0] st, input int rn);
    exp_t e;
    e.cyc = cyc + dly; e.is_err = 1'b0; e.err = '0; e.st = st; e.rn = 16'(rn); e.name = nm;
    e.on   = (st == LCK) || (st == HLD);
    e.hold = (st == HLD);
    e.lk   = (st == LCK) || (st == HLD);
    sb.push_back(e);
  endtask

  task automatic check_entry(input exp_t e);
    total++;
    if (e.is_err) begin
      if (err_out === e.err) passed++;
      else $display("FAIL %s: err_out got %0d expected %0d (cycle %0d)", e.name, err_out, e.err, cyc);
    end else begin
      if ({state, on_out, hold_out, locked, relock_num} === {e.st, e.on, e.hold, e.lk, e.rn}) passed++;
      else $display("FAIL %s: state/on/hold/locked/relock got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (cycle %0d)",
                    e.name, state, on_out, hold_out, locked, relock_num,
                    e.st, e.on, e.hold, e.lk, e.rn, cyc);
    end
  endtask

  // Monitor: compare every entry due this cycle, flag any entry already overdue
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) check_entry(sb[i]);
      else if (sb[i].cyc < cyc) begin
        total++;
        $display("FAIL %s: overdue, due cycle %0d seen at %0d", sb[i].name, sb[i].cyc, cyc);
      end else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input int s, input int sp);
    s_in = S'(s);
    setpoint = S'(sp);
  endtask

  initial begin
    rst_n = 1'b0; lock_en = 1'b0; hold_req = 1'b0;
    drv(0, 0); thr = 24'd100; acq_cnt = 24'd5; lost_cnt = 24'd3;
    step(1);
    exp_err(0, "rst_err", 0);
    exp_fsm(0, "rst_fsm", IDLE, 0);
    step(1);
    rst_n = 1'b1;

    // Saturation and plain differences
    drv(POS, -POS - 1);   exp_err(1, "sat_pos", POS);    step(1);
    drv(-POS - 1, POS);   exp_err(1, "sat_neg", -POS);   step(1);
    drv(1000, 300);       exp_err(1, "diff_a", 700);     step(1);
    drv(-5, 20);          exp_err(1, "diff_b", -25);
    exp_fsm(1, "idle_disabled", IDLE, 0);                step(1);

    // Acquisition with a one-cycle out-of-window glitch restarting the count
    lock_en = 1'b1; drv(200, 0);
    exp_fsm(1, "enter_acq", ACQ, 0);
    step(3);
    exp_err(1, "win_err", 50);
    exp_err(3, "glitch_err", -101);
    exp_fsm(8, "acq_pre", ACQ, 0);
    exp_fsm(9, "acq_lock", LCK, 0);
    drv(50, 0); step(1);
    drv(50, 0); step(1);
    drv(-101, 0); step(1);
    drv(-50, 0); step(7);

    // Short loss tolerated, then a full lost_cnt loss
    exp_fsm(4, "loss2_a", LCK, 0);
    exp_fsm(5, "loss2_b", LCK, 0);
    drv(500, 0); step(2);
    drv(0, 0); step(4);
    exp_err(1, "loss_err", 500);
    exp_fsm(3, "loss3_pre", LCK, 0);
    exp_fsm(4, "loss3", ACQ, 1);
    drv(500, 0); step(3);
    drv(0, 0);
    exp_fsm(6, "relock", LCK, 1);
    step(7);

    // Hold with a large error, release with a fresh lost count
    hold_req = 1'b1; drv(500, 0);
    exp_fsm(1, "hold_on", HLD, 1);
    exp_fsm(10, "hold_10", HLD, 1);
    step(10);
    hold_req = 1'b0;
    exp_fsm(1, "unhold", LCK, 1);
    exp_fsm(3, "fresh_cnt", LCK, 1);
    exp_fsm(4, "post_hold_loss", ACQ, 2);
    step(5);

    // Zero dwell counts behave as one
    acq_cnt = '0; lost_cnt = '0; drv(0, 0);
    exp_fsm(1, "z_acq_pre", ACQ, 2);
    exp_fsm(2, "z_lock", LCK, 2);
    step(2);
    drv(500, 0);
    exp_fsm(1, "z_drop_pre", LCK, 2);
    exp_fsm(2, "z_drop", ACQ, 3);
    step(2);
    drv(0, 0);
    exp_fsm(2, "z_relock", LCK, 3);
    step(2);

    // lock_en drop from HOLD, then async reset from HOLD
    hold_req = 1'b1;
    exp_fsm(1, "hold5", HLD, 3); step(1);
    lock_en = 1'b0;
    exp_fsm(1, "en_off", IDLE, 3);
    exp_err(1, "en_off_err", 0); step(1);
    lock_en = 1'b1;
    exp_fsm(1, "re_acq", ACQ, 3);
    exp_fsm(2, "re_lock", LCK, 3);
    exp_fsm(3, "re_hold", HLD, 3);
    step(2);
    drv(700, 0);
    exp_err(1, "pre_rst_err", 700);
    step(2);
    rst_n = 1'b0;
    exp_fsm(0, "rst_async", IDLE, 0);
    exp_err(0, "rst_async_err", 0);
    step(1);
    rst_n = 1'b1;
    exp_fsm(1, "post_rst", ACQ, 0);
    exp_err(1, "post_rst_err", 700);
    step(1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    foreach (sb[i]) begin
      total++;
      $display("FAIL %s: never checked, due cycle %0d", sb[i].name, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
